// File: rtl/pht_satcnt_array.sv
// ============================================================================
// Module  : pht_satcnt_array
// Brief   : Pattern history table of saturating counters. It serves registered
//           multi-port lookups and one read-modify-write update per cycle, and
//           clears itself after reset or flush.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pht_satcnt_array #(
    parameter int LOGINDEXSIZE = 10,
    parameter int INDEXSIZE    = 1 << LOGINDEXSIZE,
    parameter int SATCNTWIDTH  = 2,
    parameter int SATCNTINIT   = 1 << (SATCNTWIDTH - 1),
    parameter int NRDPORTS     = 2
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             pht_flush_i,
    input  logic [NRDPORTS*LOGINDEXSIZE-1:0] pht_rd_index_i,
    input  logic [LOGINDEXSIZE-1:0]          pht_wt_index_i,
    input  logic                             pht_cm_brdir_we_i,
    input  logic                             pht_cm_brdir_i,
    output logic [NRDPORTS-1:0]              pht_br_pred_o,
    output logic [NRDPORTS-1:0]              pht_br_conf_o,
    output logic                             pht_ready_o
);

    localparam logic [0:0]              S_INIT   = 1'b0;
    localparam logic [0:0]              S_IDLE   = 1'b1;
    localparam logic [SATCNTWIDTH-1:0]  C_INIT   = SATCNTINIT[SATCNTWIDTH-1:0];
    localparam logic [SATCNTWIDTH-1:0]  C_MAX    = {SATCNTWIDTH{1'b1}};
    localparam logic [SATCNTWIDTH-1:0]  C_ONE    = SATCNTWIDTH'(1);
    localparam logic [LOGINDEXSIZE-1:0] C_LAST   = LOGINDEXSIZE'(INDEXSIZE - 1);
    localparam logic [LOGINDEXSIZE-1:0] C_IDXONE = LOGINDEXSIZE'(1);

    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic [LOGINDEXSIZE-1:0] r_clr_idx;
    logic                    r_u1_valid;
    logic                    r_u1_dir;
    logic [LOGINDEXSIZE-1:0] r_u1_idx;
    logic [SATCNTWIDTH-1:0]  r_table [INDEXSIZE];

    logic                    w_ready;
    logic                    w_clr_we;
    logic                    w_u2_we;
    logic                    w_tbl_we;
    logic [LOGINDEXSIZE-1:0] w_tbl_addr;
    logic [SATCNTWIDTH-1:0]  w_tbl_data;
    logic [SATCNTWIDTH-1:0]  w_u2_cnt;
    logic [SATCNTWIDTH-1:0]  w_u2_new;

    function automatic logic [SATCNTWIDTH-1:0] f_sat(input logic [SATCNTWIDTH-1:0] cnt,
                                                     input logic                   dir);
        if (dir) begin
            return (cnt == C_MAX) ? cnt : cnt + C_ONE;
        end
        return (cnt == '0) ? cnt : cnt - C_ONE;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT: begin
                if (pht_flush_i) begin
                    w_state_nxt = S_INIT;
                end else if (r_clr_idx == C_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (pht_flush_i) begin
                    w_state_nxt = S_INIT;
                end
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        w_ready  = 1'b0;
        w_clr_we = 1'b0;
        case (r_state)
            S_INIT:  w_clr_we = ~pht_flush_i;
            S_IDLE:  w_ready  = 1'b1;
            default: w_ready  = 1'b0;
        endcase
    end

    assign pht_ready_o = w_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_clr_idx <= '0;
        end else if (pht_flush_i || (r_state != S_INIT) || (r_clr_idx == C_LAST)) begin
            r_clr_idx <= '0;
        end else begin
            r_clr_idx <= r_clr_idx + C_IDXONE;
        end
    end

    // A flush discards the staged update, so it can never land after the clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_u1_valid <= 1'b0;
            r_u1_idx   <= '0;
            r_u1_dir   <= 1'b0;
        end else begin
            r_u1_valid <= pht_cm_brdir_we_i && w_ready && !pht_flush_i;
            if (pht_cm_brdir_we_i && w_ready) begin
                r_u1_idx <= pht_wt_index_i;
                r_u1_dir <= pht_cm_brdir_i;
            end
        end
    end

    assign w_u2_cnt   = r_table[r_u1_idx];
    assign w_u2_new   = f_sat(w_u2_cnt, r_u1_dir);
    assign w_u2_we    = r_u1_valid && !pht_flush_i && (r_state == S_IDLE);
    assign w_tbl_we   = w_clr_we | w_u2_we;
    assign w_tbl_addr = w_clr_we ? r_clr_idx : r_u1_idx;
    assign w_tbl_data = w_clr_we ? C_INIT : w_u2_new;

    always_ff @(posedge clock) begin
        if (w_tbl_we) begin
            r_table[w_tbl_addr] <= w_tbl_data;
        end
    end

    for (genvar p = 0; p < NRDPORTS; p++) begin : g_rd
        logic [LOGINDEXSIZE-1:0] w_idx;
        logic [SATCNTWIDTH-1:0]  w_cnt;
        logic                    r_pred;
        logic                    r_conf;

        assign w_idx = pht_rd_index_i[p*LOGINDEXSIZE +: LOGINDEXSIZE];
        // Write-first: a lookup colliding with the committing update sees the new count.
        assign w_cnt = (w_u2_we && (w_idx == r_u1_idx)) ? w_u2_new : r_table[w_idx];

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_pred <= 1'b0;
                r_conf <= 1'b0;
            end else if (r_state == S_INIT) begin
                r_pred <= C_INIT[SATCNTWIDTH-1];
                r_conf <= 1'b0;
            end else begin
                r_pred <= w_cnt[SATCNTWIDTH-1];
                r_conf <= (w_cnt == '0) || (w_cnt == C_MAX);
            end
        end

        assign pht_br_pred_o[p] = r_pred;
        assign pht_br_conf_o[p] = r_conf;
    end

endmodule

`default_nettype wire

// File: tb/tb_pht_satcnt_array.sv
// ============================================================================
// Module  : tb_pht_satcnt_array
// Brief   : Scoreboard bench for pht_satcnt_array with a 2-bit and a 3-bit
//           counter instance and 16 entries each.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pht_satcnt_array;

    localparam int LOG = 4;
    localparam int NP  = 2;

    typedef struct {
        logic       chk3;
        logic [1:0] pred;
        logic [1:0] conf;
        logic [1:0] pred3;
        logic [1:0] conf3;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              flush;
    logic              we;
    logic              we3;
    logic              dir;
    logic [NP*LOG-1:0] rd_index;
    logic [LOG-1:0]    wt_index;
    logic [NP-1:0]     pred, conf, pred3, conf3;
    logic              ready, ready3;

    logic              lk_req = 1'b0;
    logic              lk_vld;
    exp_t              q[$];
    int                checks   = 0;
    int                failures = 0;

    always #5 clock = ~clock;

    pht_satcnt_array #(.LOGINDEXSIZE(LOG), .SATCNTWIDTH(2), .NRDPORTS(NP)) u_dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .pht_flush_i      (flush),
        .pht_rd_index_i   (rd_index),
        .pht_wt_index_i   (wt_index),
        .pht_cm_brdir_we_i(we),
        .pht_cm_brdir_i   (dir),
        .pht_br_pred_o    (pred),
        .pht_br_conf_o    (conf),
        .pht_ready_o      (ready)
    );

    pht_satcnt_array #(.LOGINDEXSIZE(LOG), .SATCNTWIDTH(3), .NRDPORTS(NP)) u_dut3 (
        .clock            (clock),
        .reset_n          (reset_n),
        .pht_flush_i      (1'b0),
        .pht_rd_index_i   (rd_index),
        .pht_wt_index_i   (wt_index),
        .pht_cm_brdir_we_i(we3),
        .pht_cm_brdir_i   (dir),
        .pht_br_pred_o    (pred3),
        .pht_br_conf_o    (conf3),
        .pht_ready_o      (ready3)
    );

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Registered lookups: the response belongs to the request sampled one edge earlier.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) lk_vld <= 1'b0;
        else          lk_vld <= lk_req;
    end

    always @(negedge clock) begin : mon
        exp_t e;
        if (lk_vld) begin
            if (q.size() == 0) begin
                chk("lk_underflow", 4'd1, 4'd0);
            end else begin
                e = q.pop_front();
                chk("lk_pred", {2'b0, pred}, {2'b0, e.pred});
                chk("lk_conf", {2'b0, conf}, {2'b0, e.conf});
                if (e.chk3) begin
                    chk("lk_pred3", {2'b0, pred3}, {2'b0, e.pred3});
                    chk("lk_conf3", {2'b0, conf3}, {2'b0, e.conf3});
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
        lk_req = 1'b0;
        we     = 1'b0;
        we3    = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic look(input logic [3:0] i0, input logic [3:0] i1,
                        input logic [1:0] p, input logic [1:0] c,
                        input logic k3, input logic [1:0] p3, input logic [1:0] c3);
        exp_t e;
        e.chk3  = k3;
        e.pred  = p;
        e.conf  = c;
        e.pred3 = p3;
        e.conf3 = c3;
        q.push_back(e);
        rd_index = {i1, i0};
        lk_req   = 1'b1;
    endtask

    task automatic upd(input logic [3:0] idx, input logic d);
        we       = 1'b1;
        wt_index = idx;
        dir      = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n  = 1'b0;
        flush    = 1'b0;
        we       = 1'b0;
        we3      = 1'b0;
        dir      = 1'b0;
        wt_index = '0;
        rd_index = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", {3'b0, ready}, 4'd0);
        chk("rst_pred", {2'b0, pred}, 4'd0);
        chk("rst_conf", {2'b0, conf}, 4'd0);
        reset_n = 1'b1;

        // Clear after reset: 16 cycles not ready, lookups meanwhile report weakly taken
        for (int k = 1; k <= 16; k++) begin
            look(4'(k - 1), 4'(16 - k), 2'b11, 2'b00, 1'b0, 2'b00, 2'b00);
            cyc();
            chk("init_ready", {3'b0, ready}, 4'(k == 16));
        end
        for (int i = 0; i < 16; i += 2) begin
            look(4'(i), 4'(i + 1), 2'b11, 2'b00, 1'b1, 2'b11, 2'b00);
            cyc();
        end

        // Saturation up and down on idx 5
        repeat (3) begin upd(4'd5, 1'b1); cyc(); end
        look(4'd5, 4'd0, 2'b11, 2'b01, 1'b0, 2'b00, 2'b00);
        cyc();
        repeat (4) begin upd(4'd5, 1'b0); cyc(); end
        look(4'd5, 4'd0, 2'b10, 2'b01, 1'b0, 2'b00, 2'b00);
        cyc();
        upd(4'd5, 1'b1);
        cyc();
        look(4'd5, 4'd0, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00);
        cyc();

        // Back-to-back updates to idx 7 on both widths
        repeat (2) begin upd(4'd7, 1'b1); we3 = 1'b1; cyc(); end
        look(4'd7, 4'd7, 2'b11, 2'b11, 1'b1, 2'b11, 2'b00);
        cyc();
        wt_index = 4'd7;
        dir      = 1'b1;
        we3      = 1'b1;
        cyc();
        look(4'd7, 4'd7, 2'b11, 2'b11, 1'b1, 2'b11, 2'b11);
        cyc();

        // Lookup colliding with the committing write on idx 9
        upd(4'd9, 1'b0);
        cyc();
        cyc();
        upd(4'd9, 1'b1);
        look(4'd9, 4'd8, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00);
        cyc();
        look(4'd9, 4'd8, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00);
        cyc();

        // Flush with an update pending
        upd(4'd3, 1'b1);
        cyc();
        flush = 1'b1;
        cyc();
        chk("flush_ready", {3'b0, ready}, 4'd0);
        for (int k = 1; k <= 16; k++) begin
            cyc();
            chk("flush_init_ready", {3'b0, ready}, 4'(k == 16));
        end
        look(4'd3, 4'd5, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00);
        cyc();
        look(4'd7, 4'd9, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00);
        cyc();

        // Asynchronous reset in the middle of a clear, with an update request held
        flush    = 1'b1;
        rd_index = {4'd4, 4'd4};
        cyc();
        repeat (3) begin upd(4'd4, 1'b1); cyc(); end
        chk("pre_rst_pred", {2'b0, pred}, 4'd3);
        upd(4'd4, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_pred", {2'b0, pred}, 4'd0);
        chk("arst_conf", {2'b0, conf}, 4'd0);
        chk("arst_ready", {3'b0, ready}, 4'd0);
        repeat (3) begin upd(4'd4, 1'b1); cyc(); end
        reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            upd(4'd4, 1'b1);
            cyc();
            chk("rerst_ready", {3'b0, ready}, 4'(k == 16));
        end
        look(4'd4, 4'd4, 2'b11, 2'b00, 1'b1, 2'b11, 2'b00);
        cyc();
        cyc();
        chk("queue_empty", {3'b0, q.size() == 0}, 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
